// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central stall/flush sequencer for a 5-stage pipeline. It handles three hazard sources:
//   - load-use data hazards;
//   - taken branches resolved at the EX/MEM boundary;
//   - multi-cycle data-memory accesses, guarded by a timeout watchdog.
// It also keeps saturating counters of stall cycles and branch flushes.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   id_rs1/id_rs2       - source register indices of the instruction in ID
//   id_uses_rs1/rs2     - the ID instruction actually reads that source
//   ex_rd, ex_mem_read  - destination and load flag of the ID/EX instruction
//   mem_branch_taken    - taken branch at the EX/MEM output
//   mem_access          - EX/MEM instruction reads or writes data memory
//   dmem_ready          - data memory completes the access this cycle
//   pc_write            - PC update enable
//   pc_redirect         - select the branch target for the next PC
//   *_stall / *_flush   - hold / clear controls for the pipeline registers
//   mem_timeout_err     - sticky flag: data memory exceeded MEM_TIMEOUT wait cycles
//   stall_cycles        - saturating count of cycles with any stall asserted
//   branch_flushes      - saturating count of taken-branch flushes
//   fsm_state           - debug view of the sequencer state (0 RUN, 1 MEM_WAIT, 2 ERROR)
//
// Control outputs are combinational from the registered state and the current inputs.
// Only the state, the wait counter, the error flag and the performance counters are registered.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             mem_branch_taken,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             pc_redirect,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] branch_flushes,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    // wait_cnt equals this value on the last wait cycle that is still tolerated.
    localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

    state_t      state;
    logic [15:0] wait_cnt;

    logic mem_hold;
    logic load_use;
    logic hold_all;
    logic run_rules;
    logic do_branch;
    logic do_bubble;
    logic any_stall;

    assign mem_hold = mem_access & ~dmem_ready;
    assign load_use = ex_mem_read & (ex_rd != 5'd0) &
                      ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                       (id_uses_rs2 & (id_rs2 == ex_rd)));

    // Freeze IF..EX and put a bubble into WB. This happens:
    //   - on a new memory hold in RUN;
    //   - on every non-ready cycle in MEM_WAIT;
    //   - always in ERROR.
    assign hold_all = (state == ST_ERROR) |
                      ((state == ST_MEM_WAIT) & ~dmem_ready) |
                      ((state == ST_RUN) & mem_hold);

    // The dmem_ready cycle of MEM_WAIT follows the RUN rules. A branch held in EX/MEM
    // during the wait is therefore acted on in that same cycle.
    assign run_rules = ~hold_all;
    assign do_branch = run_rules & mem_branch_taken;
    // A taken branch squashes the ID instruction, so its load-use hazard is moot.
    assign do_bubble = run_rules & ~mem_branch_taken & load_use;

    // Each register receives either a stall or a flush, never both.
    always_comb begin
        pc_write     = 1'b1;
        pc_redirect  = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        if (!reset) begin
            pc_write     = ~(hold_all | do_bubble);
            pc_redirect  = do_branch;
            if_id_stall  = hold_all | do_bubble;
            if_id_flush  = do_branch;
            id_ex_stall  = hold_all;
            id_ex_flush  = do_branch | do_bubble;
            ex_mem_stall = hold_all;
            ex_mem_flush = do_branch;
            mem_wb_flush = hold_all;
        end
    end

    assign any_stall = if_id_stall | id_ex_stall | ex_mem_stall;
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_RUN;
            wait_cnt        <= 16'd0;
            mem_timeout_err <= 1'b0;
            stall_cycles    <= '0;
            branch_flushes  <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (mem_hold) begin
                        state    <= ST_MEM_WAIT;
                        wait_cnt <= 16'd1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (dmem_ready) begin
                        state    <= ST_RUN;
                        wait_cnt <= 16'd0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state           <= ST_ERROR;
                        mem_timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                ST_ERROR: begin
                    // Only reset leaves ERROR.
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase

            if (any_stall && (stall_cycles != {CNT_W{1'b1}}))
                stall_cycles <= stall_cycles + 1'b1;
            if (do_branch && (branch_flushes != {CNT_W{1'b1}}))
                branch_flushes <= branch_flushes + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4).
// Inputs change on the falling edge. Combinational controls are checked 1ns later.
// Registered values are checked at the next falling edge.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_mem_read;
  logic       mem_branch_taken, mem_access, dmem_ready;
  logic       pc_write, pc_redirect, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic       ex_mem_stall, ex_mem_flush, mem_wb_flush, mem_timeout_err;
  logic [3:0] stall_cycles, branch_flushes;
  logic [1:0] fsm_state;

  int n_assert = 0;
  int n_fail   = 0;

  // Control vector: {pc_write, pc_redirect, if_id_stall, if_id_flush, id_ex_stall,
  //                  id_ex_flush, ex_mem_stall, ex_mem_flush, mem_wb_flush}
  localparam logic [8:0] C_IDLE = 9'b1_0_0_0_0_0_0_0_0;
  localparam logic [8:0] C_LU   = 9'b0_0_1_0_0_1_0_0_0;
  localparam logic [8:0] C_BR   = 9'b1_1_0_1_0_1_0_1_0;
  localparam logic [8:0] C_HOLD = 9'b0_0_1_0_1_0_1_0_1;

  logic [8:0] ctl;
  assign ctl = {pc_write, pc_redirect, if_id_stall, if_id_flush, id_ex_stall,
                id_ex_flush, ex_mem_stall, ex_mem_flush, mem_wb_flush};

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .mem_branch_taken(mem_branch_taken),
    .mem_access(mem_access), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .pc_redirect(pc_redirect),
    .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
    .ex_mem_stall(ex_mem_stall), .ex_mem_flush(ex_mem_flush),
    .mem_wb_flush(mem_wb_flush), .mem_timeout_err(mem_timeout_err),
    .stall_cycles(stall_cycles), .branch_flushes(branch_flushes), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
    mem_branch_taken = 1'b0; mem_access = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd);
    ex_mem_read = 1'b1; ex_rd = rd; id_rs1 = rd; id_uses_rs1 = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    clear_in();
    reset = 1'b1;
    tick(); tick();
    // Reset forces pc_write=1 and all other controls low, even with a branch present.
    mem_branch_taken = 1'b1;
    #1 chk("reset_ctl", 32'(ctl), 32'(C_IDLE));
    chk("reset_state", 32'(fsm_state), 0);
    chk("reset_stallcnt", 32'(stall_cycles), 0);
    chk("reset_brcnt", 32'(branch_flushes), 0);
    chk("reset_err", 32'(mem_timeout_err), 0);
    tick();
    clear_in();
    reset = 1'b0;

    // Load-use on rs1: one bubble.
    set_lu(5'd5);
    #1 chk("lu_rs1_ctl", 32'(ctl), 32'(C_LU));
    tick();
    chk("lu_rs1_stallcnt", 32'(stall_cycles), 1);
    // ex_rd = 0 is never a hazard.
    set_lu(5'd0);
    #1 chk("lu_rd0_ctl", 32'(ctl), 32'(C_IDLE));
    tick();
    chk("lu_rd0_stallcnt", 32'(stall_cycles), 1);
    // Load-use through rs2 only.
    clear_in();
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b1; id_rs1 = 5'd7;
    #1 chk("lu_rs2_ctl", 32'(ctl), 32'(C_LU));
    // Index matches, but the instruction does not read the register.
    id_uses_rs2 = 1'b0;
    #1 chk("lu_unused_ctl", 32'(ctl), 32'(C_IDLE));
    id_uses_rs2 = 1'b1;
    tick();
    chk("lu_rs2_stallcnt", 32'(stall_cycles), 2);

    // A taken branch with a concurrent load-use gives flushes and no stall.
    clear_in();
    set_lu(5'd9);
    mem_branch_taken = 1'b1;
    #1 chk("br_ctl", 32'(ctl), 32'(C_BR));
    tick();
    chk("br_cnt", 32'(branch_flushes), 1);
    chk("br_stallcnt", 32'(stall_cycles), 2);

    // Three memory wait cycles, then the access completes.
    clear_in();
    mem_access = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("memw_hold%0d", i), 32'(ctl), 32'(C_HOLD));
      tick();
      chk($sformatf("memw_state%0d", i), 32'(fsm_state), 1);
    end
    dmem_ready = 1'b1;
    #1 chk("memw_ready_ctl", 32'(ctl), 32'(C_IDLE));
    tick();
    chk("memw_state_after", 32'(fsm_state), 0);
    chk("memw_stallcnt", 32'(stall_cycles), 5);
    chk("memw_err", 32'(mem_timeout_err), 0);

    // A branch held during the memory wait is redirected on the ready cycle.
    clear_in();
    mem_access = 1'b1; mem_branch_taken = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1 chk($sformatf("membr_hold%0d", i), 32'(ctl), 32'(C_HOLD));
      tick();
    end
    chk("membr_brcnt_hold", 32'(branch_flushes), 1);
    dmem_ready = 1'b1;
    #1 chk("membr_ready_ctl", 32'(ctl), 32'(C_BR));
    tick();
    chk("membr_brcnt", 32'(branch_flushes), 2);
    chk("membr_stallcnt", 32'(stall_cycles), 7);

    // Timeout: after 4 wait cycles the block enters ERROR.
    clear_in();
    mem_access = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_err_pre%0d", i), 32'(mem_timeout_err), 0);
      #1 chk($sformatf("to_hold%0d", i), 32'(ctl), 32'(C_HOLD));
      tick();
    end
    chk("to_err", 32'(mem_timeout_err), 1);
    chk("to_state", 32'(fsm_state), 2);
    chk("to_stallcnt", 32'(stall_cycles), 11);
    // ERROR ignores dmem_ready and branches.
    dmem_ready = 1'b1; mem_branch_taken = 1'b1;
    #1 chk("err_ctl", 32'(ctl), 32'(C_HOLD));
    tick();
    chk("err_stallcnt", 32'(stall_cycles), 12);
    chk("err_brcnt", 32'(branch_flushes), 2);
    tick(); tick(); tick();
    chk("err_stallcnt_14", 32'(stall_cycles), 15);
    tick(); tick();
    chk("err_stallcnt_sat", 32'(stall_cycles), 15);
    chk("err_state_hold", 32'(fsm_state), 2);

    // A reset pulse clears everything.
    reset = 1'b1;
    #1 chk("rst_err_ctl", 32'(ctl), 32'(C_IDLE));
    tick();
    reset = 1'b0;
    clear_in();
    chk("rst_err_state", 32'(fsm_state), 0);
    chk("rst_err_err", 32'(mem_timeout_err), 0);
    chk("rst_err_stallcnt", 32'(stall_cycles), 0);
    chk("rst_err_brcnt", 32'(branch_flushes), 0);

    // Reset in the middle of a memory wait.
    mem_access = 1'b1;
    tick(); tick();
    chk("rst_mw_pre", 32'(fsm_state), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_in();
    chk("rst_mw_state", 32'(fsm_state), 0);
    #1 chk("rst_mw_ctl", 32'(ctl), 32'(C_IDLE));
    @(negedge clk);

    // Saturation of branch_flushes: 17 taken branches give 15.
    mem_branch_taken = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    chk("brsat_14", 32'(branch_flushes), 14);
    for (int i = 0; i < 3; i++) tick();
    chk("brsat_17", 32'(branch_flushes), 15);
    chk("brsat_stallcnt", 32'(stall_cycles), 0);

    // Saturation of stall_cycles: 20 load-use cycles give 15.
    clear_in();
    set_lu(5'd3);
    for (int i = 0; i < 13; i++) tick();
    chk("stsat_13", 32'(stall_cycles), 13);
    for (int i = 0; i < 7; i++) tick();
    chk("stsat_20", 32'(stall_cycles), 15);
    clear_in();
    #1 chk("final_ctl", 32'(ctl), 32'(C_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the stall and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus PC write-enable and redirect select.
- Handles three hazard sources:
  - load-use data hazards;
  - branches resolved at the EX/MEM boundary;
  - multi-cycle data-memory accesses, with a timeout watchdog.
- Keeps saturating performance counters for stall cycles and branch flushes.

Parameters:
MEM_TIMEOUT, 64, max consecutive dmem wait cycles before entering ERROR (legal range 2..65535)
CNT_W, 16, width of performance counters

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
id_rs1  input  5  rs1 index of instruction in ID
id_rs2  input  5  rs2 index of instruction in ID
id_uses_rs1  input  1  ID instruction reads rs1
id_uses_rs2  input  1  ID instruction reads rs2
ex_rd  input  5  rd held in ID/EX output
ex_mem_read  input  1  ID/EX instruction is a load
mem_branch_taken  input  1  branch_taken from EX/MEM output
mem_access  input  1  EX/MEM mem_read or mem_write asserted
dmem_ready  input  1  data memory completes access this cycle
pc_write  output  1  PC update enable
pc_redirect  output  1  select branch target for next PC
if_id_stall  output  1  hold IF/ID
if_id_flush  output  1  clear IF/ID
id_ex_stall  output  1  hold ID/EX
id_ex_flush  output  1  clear ID/EX (bubble)
ex_mem_stall  output  1  hold EX/MEM
ex_mem_flush  output  1  clear EX/MEM
mem_wb_flush  output  1  clear MEM/WB (bubble into WB)
mem_timeout_err  output  1  sticky timeout error
stall_cycles  output  CNT_W  cycles with any stall asserted, saturating
branch_flushes  output  CNT_W  taken-branch flush events, saturating

Behaviour:
- Reset, synchronous, sampled on posedge clk:
  - state=RUN, wait_cnt=0, mem_timeout_err=0, both counters=0.
- While reset is high, outputs are forced:
  - pc_write=1;
  - all stall, flush and redirect outputs =0.
- Control outputs are combinational from state plus current inputs, so they act at the same edge. State and counters are registered.
- Hazard conditions:
  - mem_hold = mem_access & !dmem_ready.
  - load_use = ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- FSM state RUN, priority mem_hold > mem_branch_taken > load_use:
  - mem_hold:
    - pc_write=0; if_id_stall=id_ex_stall=ex_mem_stall=1; mem_wb_flush=1.
    - Next state MEM_WAIT, wait_cnt=1.
    - A simultaneous branch is not lost: EX/MEM is held, so mem_branch_taken is re-presented later.
  - mem_branch_taken (no mem_hold):
    - pc_redirect=1, pc_write=1; if_id_flush=id_ex_flush=ex_mem_flush=1.
    - branch_flushes += 1.
    - Any concurrent load_use is ignored, because the ID instruction is squashed.
  - load_use only:
    - pc_write=0; if_id_stall=1; id_ex_flush=1 (exactly one bubble).
    - ex_mem and mem_wb run normally.
  - none: pc_write=1, all other outputs 0.
- FSM state MEM_WAIT:
  - While !dmem_ready: same outputs as mem_hold; wait_cnt += 1.
  - If wait_cnt == MEM_TIMEOUT-1 and still !dmem_ready: next state ERROR, mem_timeout_err=1.
  - On dmem_ready: this cycle is evaluated with RUN rules (mem_hold=0); next state RUN, wait_cnt=0.
  - Branch and load-use handling resume in that same cycle.
- FSM state ERROR:
  - pc_write=0; if_id, id_ex and ex_mem stall=1; mem_wb_flush=1; all other outputs 0.
  - Held until reset; dmem_ready is ignored.
- Stall-inclusive conditions: never assert both stall and flush on the same register in the same cycle. Flush has priority in the register itself, but this block must not generate both.
- stall_cycles: +1 on every non-reset cycle where any of if_id_stall, id_ex_stall or ex_mem_stall =1, including ERROR. Holds at 2^CNT_W-1.
- branch_flushes: saturates at 2^CNT_W-1.
- Reset mid-MEM_WAIT or in ERROR: returns to RUN next cycle, error cleared.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 for one cycle -> pc_write=0, if_id_stall=1, id_ex_flush=1 that cycle; stall_cycles 0->1. Same with ex_rd=0 -> no stall.
- Branch: mem_branch_taken=1 -> pc_redirect=1, if_id/id_ex/ex_mem flush=1, branch_flushes=1. Concurrent load_use -> no stall asserted.
- Mem wait: mem_access=1, dmem_ready=0 for 3 cycles then 1 -> stall outputs and mem_wb_flush high for exactly 3 cycles; state RUN after; stall_cycles=3.
- Mem wait plus branch: mem_hold for 2 cycles with mem_branch_taken=1 throughout -> no redirect during the hold; redirect and flushes on the dmem_ready cycle; branch_flushes=1.
- Timeout: MEM_TIMEOUT=4, dmem_ready held 0 -> mem_timeout_err=1 after the 4th wait cycle; stalls persist after dmem_ready=1; reset pulse clears everything.
- Saturation: CNT_W=4, 20 stall cycles -> stall_cycles=15.
